fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, number of cycles without imem_ack that counts as a timeout (used only with FETCH_TIMEOUT_EN).
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 branch  input  1  current instruction is a conditional branch (from execute).
REQ-006 jump  input  1  current instruction is a jump (from execute).
REQ-007 zero  input  1  ALU zero flag for the current instruction.
REQ-008 imm16  input  16  branch offset field of the current instruction.
REQ-009 instr_index  input  26  jump target field of the current instruction.
REQ-010 ex_done  input  1  execute has consumed instr this cycle; redirect inputs are valid.
REQ-011 imem_ack  input  1  instruction memory has returned data this cycle.
REQ-012 imem_rdata  input  32  instruction word; valid only when imem_ack=1.
REQ-013 imem_req  output  1  fetch request to instruction memory.
REQ-014 imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-015 pc  output  32  address of the instruction currently fetched or held.
REQ-016 instr  output  32  held instruction word to execute.
REQ-017 instr_valid  output  1  instr is valid and awaits ex_done.
REQ-018 fetch_err  output  1  one-cycle pulse on fetch timeout.

Function
REQ-019 FSM: states FETCH and HOLD; one state transition at most per cycle.
REQ-020 FETCH: imem_req=1, instr_valid=0; on imem_ack the unit latches imem_rdata into instr and moves to HOLD.
REQ-021 HOLD: imem_req=0, instr_valid=1, instr stable; on ex_done the unit loads pc with next_pc and moves to FETCH.
REQ-022 The unit issues the request for the next instruction in the cycle after ex_done, so minimum latency is ack-to-instr_valid 1 cycle.
REQ-023 pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-024 next_pc priority: jump -> {pc_plus4[31:28], instr_index, 2'b00}; else branch and zero -> pc_plus4 + (sign-extended imm16 << 2); else pc_plus4.
REQ-025 branch=1 with zero=0 selects pc_plus4.
REQ-026 The unit ignores imem_ack in HOLD and ignores ex_done in FETCH.
REQ-027 imem_addr[1:0] is always 2'b00.

Reset
REQ-028 RST_N=0 asynchronously forces: state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, fetch_err=0, timeout counter=0.
REQ-029 imem_req is 1 from the first rising edge after RST_N deasserts; it is 0 while RST_N=0.
REQ-030 Reset asserted during FETCH or HOLD abandons the outstanding fetch, and the unit ignores any later ack for it.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN: when defined, a counter runs in FETCH and clears on imem_ack and on entry to FETCH.
REQ-032 Timeout behaviour: when the counter reaches TIMEOUT_CYCLES without ack, fetch_err pulses for 1 cycle, the counter clears, and the request stays asserted at the same pc.
REQ-033 When FETCH_TIMEOUT_EN is not defined, the unit has no counter and fetch_err is tied to 0.

Structure
REQ-034 The shared package mips_pkg holds the state encoding, the RESET_PC default and the field widths (16, 26, 32).
REQ-035 The next_pc logic is one combinational sub-module, next_pc_calc, with inputs pc, branch, zero, jump, imm16 and instr_index, and output next_pc.

Verification
REQ-036 Release reset with RESET_PC=0 -> imem_req=1, imem_addr=0; ack with rdata 32'h2001_0005 -> next cycle instr=32'h2001_0005, instr_valid=1.
REQ-037 At pc=8, ex_done with branch=0, jump=0 -> imem_addr=12 in the next cycle.
REQ-038 At pc=8, ex_done with branch=1, zero=1, imm16=16'hFFFE -> pc=4; the same with zero=0 -> pc=12.
REQ-039 At pc=32'h1000_0010, ex_done with jump=1, branch=1, zero=1, instr_index=26'h40 -> pc=32'h1000_0100.
REQ-040 With FETCH_TIMEOUT_EN defined, hold imem_ack=0 for 16 cycles -> fetch_err pulses once, imem_req stays 1 at the same address; ack on cycle 20 -> instr_valid=1.
REQ-041 Assert RST_N=0 mid-FETCH at pc=0x40, then ack while in reset -> pc=RESET_PC, instr_valid=0, and the ack has no effect.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, field widths and
// the default reset vector.
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int IMM_W = 16;
    localparam int IDX_W = 26;

    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jump, taken conditional branch, or
// sequential pc+4.
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]  pc,
    input  logic             branch,
    input  logic             zero,
    input  logic             jump,
    input  logic [IMM_W-1:0] imm16,
    input  logic [IDX_W-1:0] instr_index,
    output logic [XLEN-1:0]  next_pc
);

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] br_off;
    logic [XLEN-1:0] jmp_tgt;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{(XLEN-IMM_W-2){imm16[IMM_W-1]}}, imm16, 2'b00};
    // Jump region comes from the incremented pc, so a wrap past 2^32 lands in segment 0.
    assign jmp_tgt  = {pc_plus4[XLEN-1:XLEN-4], instr_index, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump)
            next_pc = jmp_tgt;
        else if (branch && zero)
            next_pc = pc_plus4 + br_off;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/HOLD handshake with instruction memory and
// execute. Optional fetch timeout is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = RESET_PC_DEF,
    parameter int              TIMEOUT_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             branch,
    input  logic             jump,
    input  logic             zero,
    input  logic [IMM_W-1:0] imm16,
    input  logic [IDX_W-1:0] instr_index,
    input  logic             ex_done,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  instr,
    output logic             instr_valid,
    output logic             fetch_err
);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] next_pc;
    logic            run_q;
    logic            ack_ok;

    // run_q keeps the request low until the first edge after reset release,
    // so an ack left over from an abandoned fetch is never accepted.
    assign ack_ok = imem_ack && run_q;

    next_pc_calc u_next_pc (
        .pc          (pc_q),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .imm16       (imm16),
        .instr_index (instr_index),
        .next_pc     (next_pc)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            ST_FETCH: if (ack_ok) begin
                state_d = ST_HOLD;
                instr_d = imem_rdata;
            end
            ST_HOLD: if (ex_done) begin
                state_d = ST_FETCH;
                pc_d    = next_pc;
            end
            default: state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        imem_req    = run_q && (state_q == ST_FETCH);
        instr_valid = (state_q == ST_HOLD);
        imem_addr   = {pc_q[XLEN-1:2], 2'b00};
        pc          = pc_q;
        instr       = instr_q;
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Counts completed request cycles without ack; outside FETCH it sits at 0,
    // which also gives the clear on entry to FETCH.
    always_comb begin
        cnt_d = '0;
        err_d = 1'b0;
        if (imem_req && !imem_ack) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1))
                err_d = 1'b1;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign fetch_err = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: three instances with different reset vectors
// share stimulus so jump-region and pc wrap cases are reachable.
module tb_fetch_unit;
    import mips_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        branch, jump, zero, ex_done, imem_ack;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] imem_rdata;

    logic [2:0]       req, vld, err;
    logic [2:0][31:0] addr, pcv, ins;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) u_dut0 (
        .CLK(CLK), .RST_N(RST_N), .branch(branch), .jump(jump), .zero(zero),
        .imm16(imm16), .instr_index(instr_index), .ex_done(ex_done),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(req[0]),
        .imem_addr(addr[0]), .pc(pcv[0]), .instr(ins[0]),
        .instr_valid(vld[0]), .fetch_err(err[0]));

    fetch_unit #(.RESET_PC(32'h1000_0010), .TIMEOUT_CYCLES(16)) u_dut1 (
        .CLK(CLK), .RST_N(RST_N), .branch(branch), .jump(jump), .zero(zero),
        .imm16(imm16), .instr_index(instr_index), .ex_done(ex_done),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(req[1]),
        .imem_addr(addr[1]), .pc(pcv[1]), .instr(ins[1]),
        .instr_valid(vld[1]), .fetch_err(err[1]));

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(16)) u_dut2 (
        .CLK(CLK), .RST_N(RST_N), .branch(branch), .jump(jump), .zero(zero),
        .imm16(imm16), .instr_index(instr_index), .ex_done(ex_done),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .imem_req(req[2]),
        .imem_addr(addr[2]), .pc(pcv[2]), .instr(ins[2]),
        .instr_valid(vld[2]), .fetch_err(err[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // Called at a negedge in FETCH; returns one negedge later in HOLD.
    task automatic do_fetch(input logic [31:0] rdata);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        @(negedge CLK);
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("fetch.instr", ins[0], rdata);
        check("fetch.valid", {31'b0, vld[0]}, 32'd1);
        check("fetch.req",   {31'b0, req[0]}, 32'd0);
    endtask

    task automatic do_ex(input logic br, input logic jp, input logic z,
                         input logic [15:0] imm, input logic [25:0] idx);
        branch = br; jump = jp; zero = z; imm16 = imm; instr_index = idx;
        ex_done = 1'b1;
        @(negedge CLK);
        ex_done = 1'b0; branch = 1'b0; jump = 1'b0; zero = 1'b0;
        imm16 = '0; instr_index = '0;
        check("ex.req",   {31'b0, req[0]}, 32'd1);
        check("ex.valid", {31'b0, vld[0]}, 32'd0);
    endtask

    initial begin
        int pulses;
        int req_drop;
        logic [31:0] exp_pulses;

        RST_N = 1'b0; branch = 0; jump = 0; zero = 0; ex_done = 0; imem_ack = 0;
        imm16 = '0; instr_index = '0; imem_rdata = '0;
        repeat (3) @(negedge CLK);
        check("rst.req",    {31'b0, req[0]}, 32'd0);
        check("rst.pc",     pcv[0], 32'h0);
        check("rst.instr",  ins[0], 32'h0);
        check("rst.valid",  {31'b0, vld[0]}, 32'd0);
        check("rst.err",    {31'b0, err[0]}, 32'd0);
        check("rst.pc_hi",  pcv[2], 32'hFFFF_FFFC);

        RST_N = 1'b1;
        @(negedge CLK);
        check("boot.req",  {31'b0, req[0]}, 32'd1);
        check("boot.addr", addr[0], 32'h0);

        do_fetch(32'h2001_0005);
        // Jump wins over a taken branch; region bits come from pc+4.
        do_ex(1'b1, 1'b1, 1'b1, 16'h0004, 26'h40);
        check("jmp.pc0", pcv[0], 32'h0000_0100);
        check("jmp.pc1", pcv[1], 32'h1000_0100);
        check("jmp.pc2", pcv[2], 32'h0000_0100);

        do_fetch(32'h1111_0001);
        do_ex(1'b0, 1'b1, 1'b0, 16'h0, 26'h2);
        check("jmp8.pc", pcv[0], 32'h8);

        do_fetch(32'h1111_0002);
        do_ex(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("seq.addr", addr[0], 32'd12);

        do_fetch(32'h1111_0003);
        do_ex(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0);
        check("br12.pc", pcv[0], 32'h8);

        do_fetch(32'h1111_0004);
        do_ex(1'b1, 1'b0, 1'b1, 16'hFFFE, 26'h0);
        check("br8.pc", pcv[0], 32'h4);

        do_fetch(32'h1111_0005);
        do_ex(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("seq4.pc", pcv[0], 32'h8);

        // ex_done in FETCH must not move pc
        ex_done = 1'b1; jump = 1'b1; instr_index = 26'h3FF;
        @(negedge CLK);
        ex_done = 1'b0; jump = 1'b0; instr_index = '0;
        check("fetch_ignores_ex.pc",    pcv[0], 32'h8);
        check("fetch_ignores_ex.valid", {31'b0, vld[0]}, 32'd0);

        do_fetch(32'h1111_0006);
        // ack in HOLD must not overwrite instr
        imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        @(negedge CLK);
        imem_ack = 1'b0; imem_rdata = '0;
        check("hold_ignores_ack", ins[0], 32'h1111_0006);

        do_ex(1'b1, 1'b0, 1'b0, 16'hFFFE, 26'h0);
        check("br_nt.pc", pcv[0], 32'd12);

        do_fetch(32'h1111_0007);
        do_ex(1'b0, 1'b1, 1'b0, 16'h0, 26'h10);
        check("jmp40.addr", addr[0], 32'h40);

        pulses = 0; req_drop = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge CLK);
            if (err[0]) pulses++;
            if (!req[0] || addr[0] != 32'h40) req_drop++;
        end
`ifdef FETCH_TIMEOUT_EN
        exp_pulses = 32'd1;
`else
        exp_pulses = 32'd0;
`endif
        check("timeout.pulses", pulses, exp_pulses);
        check("timeout.req_held", req_drop, 32'd0);
        do_fetch(32'h3333_0001);

        do_ex(1'b0, 1'b1, 1'b0, 16'h0, 26'h10);
        check("refetch40.pc", pcv[0], 32'h40);

        RST_N = 1'b0;
        #1;
        check("midrst.pc",    pcv[0], 32'h0);
        check("midrst.req",   {31'b0, req[0]}, 32'd0);
        check("midrst.valid", {31'b0, vld[0]}, 32'd0);
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        imem_ack = 1'b0; imem_rdata = '0;
        check("postrst.valid", {31'b0, vld[0]}, 32'd0);
        check("postrst.instr", ins[0], 32'h0);
        check("postrst.pc",    pcv[0], 32'h0);
        check("postrst.req",   {31'b0, req[0]}, 32'd1);

        do_fetch(32'h8C22_0004);
        do_ex(1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        check("post.pc0",  pcv[0], 32'h4);
        check("wrap.pc2",  pcv[2], 32'h0);
        check("post.pc1",  pcv[1], 32'h1000_0014);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
